// File: rtl/icap_pkg.sv
// rtl/icap_pkg.sv - shared states, sequence constants and byte bit-swap for the ICAP reboot controller
package icap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_WRITE = 2'd2,
        ST_POST  = 2'd3
    } state_e;

    localparam int          SEQ_LEN  = 14;
    localparam int          IDX_W    = 4;
    localparam logic [3:0]  LAST_IDX = 4'(SEQ_LEN - 1);

    localparam logic [15:0] DUMMY    = 16'hFFFF;
    localparam logic [15:0] SYNC1    = 16'hAA99;
    localparam logic [15:0] SYNC2    = 16'h5566;
    localparam logic [15:0] GEN1_HDR = 16'h3261;
    localparam logic [15:0] GEN2_HDR = 16'h3281;
    localparam logic [15:0] GEN3_HDR = 16'h32A1;
    localparam logic [15:0] GEN4_HDR = 16'h32C1;
    localparam logic [15:0] CMD_HDR  = 16'h30A1;
    localparam logic [15:0] IPROG    = 16'h000E;
    localparam logic [15:0] NOOP     = 16'h2000;
    localparam logic [7:0]  OPCODE   = 8'h03;

    // ICAP expects each byte MSB/LSB mirrored relative to the bitstream word.
    function automatic logic [15:0] byte_bit_swap(input logic [15:0] w);
        logic [15:0] r;
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*b+j] = w[8*b+7-j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_seq_rom.sv
// rtl/icap_seq_rom.sv - combinational index-to-word lookup for the IPROG reboot sequence
module icap_seq_rom
    import icap_pkg::*;
#(
    parameter logic [23:0] BOOT_ADDR   = 24'h0C_0000,
    parameter logic [23:0] GOLDEN_ADDR = 24'h00_0000,
    parameter bit          SWAP_EN     = 1'b1
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [15:0]      word_o
);

    logic [15:0] raw_word;

    always_comb begin
        raw_word = DUMMY;
        case (idx_i)
            4'd0:    raw_word = DUMMY;
            4'd1:    raw_word = SYNC1;
            4'd2:    raw_word = SYNC2;
            4'd3:    raw_word = GEN1_HDR;
            4'd4:    raw_word = BOOT_ADDR[15:0];
            4'd5:    raw_word = GEN2_HDR;
            4'd6:    raw_word = {OPCODE, BOOT_ADDR[23:16]};
            4'd7:    raw_word = GEN3_HDR;
            4'd8:    raw_word = GOLDEN_ADDR[15:0];
            4'd9:    raw_word = GEN4_HDR;
            4'd10:   raw_word = {OPCODE, GOLDEN_ADDR[23:16]};
            4'd11:   raw_word = CMD_HDR;
            4'd12:   raw_word = IPROG;
            4'd13:   raw_word = NOOP;
            default: raw_word = DUMMY;
        endcase
    end

    assign word_o = SWAP_EN ? byte_bit_swap(raw_word) : raw_word;

endmodule

// File: rtl/icap_reboot_ctrl.sv
// rtl/icap_reboot_ctrl.sv - key-triggered ICAP IPROG sequencer with fully registered outputs
module icap_reboot_ctrl
    import icap_pkg::*;
#(
    parameter logic [23:0] BOOT_ADDR   = 24'h0C_0000,
    parameter logic [23:0] GOLDEN_ADDR = 24'h00_0000,
    parameter bit          SWAP_EN     = 1'b1
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        key_flag,
    output logic        icap_ce_n,
    output logic        icap_wr_n,
    output logic [15:0] icap_i,
    output logic        busy,
    output logic        done
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ce_n_q, ce_n_d;
    logic             wr_n_q, wr_n_d;
    logic [15:0]      data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      rom_word;

    icap_seq_rom #(
        .BOOT_ADDR   (BOOT_ADDR),
        .GOLDEN_ADDR (GOLDEN_ADDR),
        .SWAP_EN     (SWAP_EN)
    ) u_rom (
        .idx_i  (idx_q),
        .word_o (rom_word)
    );

    // Outputs trail the state by one cycle, so the busy output (not the state)
    // decides whether a key press is accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (key_flag && !busy_q) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                idx_d   = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_POST;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_POST: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ce_n_d = 1'b1;
        wr_n_d = 1'b1;
        data_d = DUMMY;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // busy still high here means POST was just left.
                done_d = busy_q;
            end
            ST_PRE: begin
                wr_n_d = 1'b0;
                busy_d = 1'b1;
            end
            ST_WRITE: begin
                ce_n_d = 1'b0;
                wr_n_d = 1'b0;
                busy_d = 1'b1;
                data_d = rom_word;
            end
            ST_POST: begin
                wr_n_d = 1'b0;
                busy_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ce_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            data_q  <= DUMMY;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ce_n_q  <= ce_n_d;
            wr_n_q  <= wr_n_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign icap_ce_n = ce_n_q;
    assign icap_wr_n = wr_n_q;
    assign icap_i    = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// tb/tb_icap_reboot_ctrl.sv - table-driven self-checking bench for icap_reboot_ctrl
module tb_icap_reboot_ctrl;

    typedef struct {
        logic        ce_n;
        logic        wr_n;
        logic        busy;
        logic        done;
        logic        chk_data;
        logic [15:0] data;
    } row_t;

    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_flag = 1'b0;
    logic        ce_n_a, wr_n_a, busy_a, done_a;
    logic [15:0] data_a;
    logic        ce_n_b, wr_n_b, busy_b, done_b;
    logic [15:0] data_b;

    int   checks = 0;
    int   failures = 0;
    row_t tbl[0:18];
    row_t idle_row;

    always #5 sclk = ~sclk;

    icap_reboot_ctrl dut_a (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .key_flag  (key_flag),
        .icap_ce_n (ce_n_a),
        .icap_wr_n (wr_n_a),
        .icap_i    (data_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    icap_reboot_ctrl #(
        .BOOT_ADDR (24'h12_3456),
        .SWAP_EN   (1'b0)
    ) dut_b (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .key_flag  (key_flag),
        .icap_ce_n (ce_n_b),
        .icap_wr_n (wr_n_b),
        .icap_i    (data_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_row(input string tag, input row_t r);
        check({tag, "_ce_n"}, 16'(ce_n_a), 16'(r.ce_n));
        check({tag, "_wr_n"}, 16'(wr_n_a), 16'(r.wr_n));
        check({tag, "_busy"}, 16'(busy_a), 16'(r.busy));
        check({tag, "_done"}, 16'(done_a), 16'(r.done));
        if (r.chk_data) check({tag, "_data"}, data_a, r.data);
    endtask

    // t is the edge offset from the accepting edge k; kx1/kx2 are extra key edges,
    // abort_at is the edge with rst_n low (0 = none), chain re-keys at edge k+18.
    task automatic run_seq(input string tag, input bit do_start, input int kx1, input int kx2,
                           input int abort_at, input bit chain, input int exp_done);
        int n_done;
        n_done = 0;
        if (do_start) begin
            @(negedge sclk); key_flag = 1'b1;
            @(negedge sclk); key_flag = 1'b0;
        end
        for (int t = 0; t <= 18; t++) begin
            if (t > 0) @(negedge sclk);
            if (abort_at != 0 && t >= abort_at)
                check_row($sformatf("%s_t%0d", tag, t), idle_row);
            else
                check_row($sformatf("%s_t%0d", tag, t), tbl[t]);
            if (done_a === 1'b1) n_done++;
            if (tag == "base") begin
                if (t == 3) check("noswap_w1", data_b, 16'hAA99);
                if (t == 6) check("noswap_w4", data_b, 16'h3456);
                if (t == 8) check("noswap_w6", data_b, 16'h0312);
            end
            key_flag = (t + 1 == kx1) || (t + 1 == kx2) || (chain && t == 17);
            rst_n    = !(t + 1 == abort_at);
        end
        key_flag = 1'b0;
        rst_n    = 1'b1;
        check({tag, "_done_count"}, 16'(n_done), 16'(exp_done));
    endtask

    // Protocol watch: any cycle with ce_n low needs wr_n low before, during and after.
    logic [2:0] ce_h = 3'b111, wr_h = 3'b111, rs_h = 3'b000;
    always @(negedge sclk) begin
        ce_h = {ce_h[1:0], ce_n_a};
        wr_h = {wr_h[1:0], wr_n_a};
        rs_h = {rs_h[1:0], rst_n};
        if (ce_h[1] == 1'b0 && rs_h == 3'b111) begin
            checks++;
            if (wr_h != 3'b000) begin
                failures++;
                $display("FAIL ce_wr_overlap: wr_n history %b with ce_n history %b", wr_h, ce_h);
            end
        end
    end

    initial begin
        logic [15:0] words[0:13];
        words = '{16'hFFFF, 16'h5599, 16'hAA66, 16'h4C86, 16'h0000, 16'h4C81, 16'hC030,
                  16'h4C85, 16'h0000, 16'h4C83, 16'hC000, 16'h0C85, 16'h0070, 16'h0400};
        idle_row = '{ce_n: 1'b1, wr_n: 1'b1, busy: 1'b0, done: 1'b0, chk_data: 1'b1, data: 16'hFFFF};
        tbl[0]  = idle_row;
        tbl[1]  = '{ce_n: 1'b1, wr_n: 1'b0, busy: 1'b1, done: 1'b0, chk_data: 1'b0, data: 16'hFFFF};
        for (int i = 0; i < 14; i++)
            tbl[2+i] = '{ce_n: 1'b0, wr_n: 1'b0, busy: 1'b1, done: 1'b0, chk_data: 1'b1, data: words[i]};
        tbl[16] = '{ce_n: 1'b1, wr_n: 1'b0, busy: 1'b1, done: 1'b0, chk_data: 1'b1, data: 16'hFFFF};
        tbl[17] = '{ce_n: 1'b1, wr_n: 1'b1, busy: 1'b0, done: 1'b1, chk_data: 1'b1, data: 16'hFFFF};
        tbl[18] = idle_row;

        rst_n = 1'b0;
        repeat (5) @(negedge sclk);
        check_row("reset", idle_row);
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        run_seq("base",    1'b1, 0, 0,  0, 1'b0, 1);
        run_seq("ignore",  1'b1, 5, 10, 0, 1'b0, 1);
        run_seq("abort",   1'b1, 0, 0,  8, 1'b0, 0);
        run_seq("restart", 1'b1, 0, 0,  0, 1'b1, 1);
        run_seq("chained", 1'b0, 0, 0,  0, 1'b0, 1);
        repeat (3) @(negedge sclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
